booth_product_accumulator: RTL and testbench
============================================

BOOTH_PRODUCT_ACCUMULATOR -- requirements
Module: booth_product_accumulator

Interface
REQ-001 Parameter ACC_W, default 36: accumulator width in bits, signed two's complement, ACC_W >= 33.
REQ-002 Parameter CNT_W, default 8: beat-counter width in bits, so a frame holds at most 2^CNT_W-1 beats.
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: synchronous active-high reset.
REQ-005 Port in_valid, input, 1: in_product and in_last are valid this cycle.
REQ-006 Port in_product, input, 32: signed product from the Booth radix-4 16-bit multiplier.
REQ-007 Port in_last, input, 1: the current beat is the final beat of the frame.
REQ-008 Port in_ready, output, 1: the block accepts a beat this cycle.
REQ-009 Port out_valid, output, 1: a frame result is held on the outputs.
REQ-010 Port out_ready, input, 1: the consumer takes the result this cycle.
REQ-011 Port out_acc, output, ACC_W: signed frame sum.
REQ-012 Port out_count, output, CNT_W: number of beats accumulated in the frame.
REQ-013 Port out_overflow, output, 1: sticky flag; the frame sum exceeded the ACC_W range.

Function
REQ-014 Beat accepted means in_valid && in_ready in the same cycle; the block SHALL ignore in_product and in_last in every other cycle.
REQ-015 The FSM SHALL have three states, IDLE, ACCUM and HOLD; IDLE is the reset state.
REQ-016 In IDLE and ACCUM, in_ready SHALL be 1; in HOLD it SHALL be 0.
REQ-017 In IDLE, an accepted beat SHALL load acc = sext(in_product) and count = 1, then move to ACCUM, or to HOLD if in_last is set.
REQ-018 In ACCUM, an accepted beat SHALL set acc = acc + sext(in_product) and count = count + 1.
REQ-019 In ACCUM, the FSM SHALL move to HOLD when in_last is set or count reaches 2^CNT_W-1 (forced frame end); otherwise it stays in ACCUM.
REQ-020 The last beat SHALL be accepted in cycle N; out_valid SHALL be 1 in cycle N+1 with out_acc and out_count final (latency 1).
REQ-021 In HOLD, out_acc, out_count and out_overflow SHALL stay stable until out_valid && out_ready.
REQ-022 When a HOLD result is taken, the FSM SHALL go to IDLE, with in_ready returning to 1 in the next cycle; no beat is accepted in the handshake cycle.
REQ-023 out_valid SHALL be 0 outside HOLD.
REQ-024 In IDLE and ACCUM, out_acc and out_count SHALL show the running values.
REQ-025 Overflow SHALL be detected on each add as operand signs equal and result sign different; out_overflow SHALL be set on detection and clear only when a new frame starts in IDLE.
REQ-026 A -32768 x -32768 product (0x40000000) SHALL be treated as positive 2^30.

Reset
REQ-027 While rst is 1 at a clock edge, the block SHALL enter IDLE with acc = 0, count = 0, out_overflow = 0, out_valid = 0 and in_ready = 1, overriding any beat or handshake in that cycle.
REQ-028 Reset SHALL abort any partial or held frame without emitting it.

Configuration
REQ-029 With BOOTH_ACC_SAT_EN defined, an overflowing add SHALL clamp acc to +(2^(ACC_W-1)-1) or -2^(ACC_W-1) according to operand sign, and later adds continue from the clamped value.
REQ-030 Without BOOTH_ACC_SAT_EN, an overflowing add SHALL wrap modulo 2^ACC_W.
REQ-031 out_overflow behaviour SHALL be identical in both builds.

Structure
REQ-032 Shared package booth_pkg SHALL hold the ACC_W and CNT_W defaults, the FSM state enum (IDLE, ACCUM, HOLD) and the saturation limit constants.
REQ-033 Sub-module booth_acc_sat_add SHALL hold the combinational sign-extend, add, overflow detect and optional clamp; the top holds the FSM, registers and handshake.

Verification
REQ-034 Single beat 56088 with in_last=1 -> out_valid next cycle; out_acc = 56088, out_count = 1, out_overflow = 0.
REQ-035 Beats -21, 100, -60000 (last), with out_ready held 0 for 5 cycles -> out_acc = -59921, out_count = 3, outputs stable and in_ready = 0 for those 5 cycles.
REQ-036 32 beats of 0x40000000, last on the 32nd -> out_overflow = 1; SAT_EN build out_acc = 0x7FFFFFFFF, non-SAT build out_acc = 0x800000000.
REQ-037 255 beats of 1, no in_last -> forced end; out_count = 255, out_acc = 255; the 256th beat waits for HOLD to be released.
REQ-038 rst pulsed after 3 of 5 beats -> no out_valid; a following frame of 7 (last) -> out_acc = 7, out_count = 1.
REQ-039 out_ready=1 held with back-to-back frames -> exactly one gap cycle between a frame's last beat and the next frame's first accepted beat beyond the HOLD cycle; each result matches its frame.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared defaults, FSM encoding and saturation limits for the Booth product accumulator.
// Limits are held at 64 bits and narrowed to ACC_W by the users (ACC_W <= 64).
package booth_pkg;

  localparam int ACC_W_DEF = 36;
  localparam int CNT_W_DEF = 8;
  localparam int PROD_W    = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [63:0] SAT_MAX_64 = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] SAT_MIN_64 = 64'h8000_0000_0000_0000;

endpackage

// File: rtl/booth_acc_sat_add.sv
// Sign-extend a 32-bit product and add it to the accumulator; combinational, no backpressure.
// Flags signed overflow; clamps to the ACC_W limits when BOOTH_ACC_SAT_EN is defined, else wraps.
module booth_acc_sat_add
  import booth_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] product,
  output logic [ACC_W-1:0]  sum,
  output logic              overflow
);

  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] raw_sum;

  assign prod_ext = {{(ACC_W-PROD_W){product[PROD_W-1]}}, product};
  assign raw_sum  = acc + prod_ext;

  // Same-sign operands producing an opposite-sign result is the only overflow case.
  assign overflow = (acc[ACC_W-1] == prod_ext[ACC_W-1]) &&
                    (raw_sum[ACC_W-1] != acc[ACC_W-1]);

`ifdef BOOTH_ACC_SAT_EN
  localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'(SAT_MAX_64 >> (64 - ACC_W));
  localparam logic [ACC_W-1:0] SAT_MIN = ACC_W'(SAT_MIN_64 >> (64 - ACC_W));

  always_comb begin
    sum = raw_sum;
    if (overflow) begin
      sum = acc[ACC_W-1] ? SAT_MIN : SAT_MAX;
    end
  end
`else
  assign sum = raw_sum;
`endif

endmodule

// File: rtl/booth_product_accumulator.sv
// Frames Booth products into a signed sum with beat count and sticky overflow; result valid 1 cycle after last beat.
// in_ready drops while a result is held until out_ready; BOOTH_ACC_SAT_EN selects clamping instead of wrapping.
module booth_product_accumulator
  import booth_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [PROD_W-1:0] in_product,
  input  logic              in_last,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic             in_ready_r;
  logic             out_valid_r;

  logic             beat_acc;
  logic [ACC_W-1:0] add_a;
  logic [ACC_W-1:0] add_sum;
  logic             add_ovf;
  logic [CNT_W-1:0] cnt_nxt;
  logic             frame_end;

  assign beat_acc = in_valid && in_ready_r;

  // A new frame adds onto zero, which also makes the first beat's overflow flag 0.
  assign add_a     = (state == IDLE) ? '0 : acc;
  assign cnt_nxt   = (state == IDLE) ? CNT_W'(1) : cnt + CNT_W'(1);
  assign frame_end = in_last || (cnt_nxt == CNT_MAX);

  booth_acc_sat_add #(
    .ACC_W (ACC_W)
  ) u_add (
    .acc      (add_a),
    .product  (in_product),
    .sum      (add_sum),
    .overflow (add_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      cnt         <= '0;
      ovf         <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (beat_acc) begin
            acc <= add_sum;
            cnt <= cnt_nxt;
            ovf <= ((state == IDLE) ? 1'b0 : ovf) | add_ovf;
            if (frame_end) begin
              state       <= HOLD;
              in_ready_r  <= 1'b0;
              out_valid_r <= 1'b1;
            end else begin
              state <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state       <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready     = in_ready_r;
  assign out_valid    = out_valid_r;
  assign out_acc      = acc;
  assign out_count    = cnt;
  assign out_overflow = ovf;

endmodule

// File: tb/tb_booth_product_accumulator.sv
// Bench for booth_product_accumulator: directed frames with literal results plus randomized traffic
// checked every cycle against a plain-arithmetic frame model (honours BOOTH_ACC_SAT_EN).
module tb_booth_product_accumulator;

  localparam int     ACC_W = 36;
  localparam int     CNT_W = 8;
  localparam longint MAXV  = 64'sd34359738367;
  localparam longint MINV  = -64'sd34359738368;
  localparam longint MODV  = 64'sd68719476736;
  localparam int     MAXB  = 255;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [31:0]       in_product = '0;
  logic              in_last = 1'b0;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [ACC_W-1:0]  out_acc;
  logic [CNT_W-1:0]  out_count;
  logic              out_overflow;

  booth_product_accumulator #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_product   (in_product),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_acc      (out_acc),
    .out_count    (out_count),
    .out_overflow (out_overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Frame model: true arithmetic sum, then wrap or clamp into the ACC_W range.
  bit     m_hold   = 1'b0;
  bit     m_active = 1'b0;
  bit     m_fresh  = 1'b1;
  longint m_acc    = 0;
  int     m_cnt    = 0;
  bit     m_ovf    = 1'b0;
  longint t_sum;
  longint t_prod;

  always @(negedge clk) begin
    chk("in_ready", in_ready, !m_hold);
    chk("out_valid", out_valid, m_hold);
    chk("out_overflow", out_overflow, m_ovf);
    if (m_active || m_fresh) begin
      chk("out_acc", $signed(out_acc), m_acc);
      chk("out_count", out_count, m_cnt);
    end
    if (rst) begin
      m_hold = 0; m_active = 0; m_fresh = 1; m_acc = 0; m_cnt = 0; m_ovf = 0;
    end else if (m_hold) begin
      if (out_ready) begin
        m_hold = 0;
        m_active = 0;
      end
    end else if (in_valid) begin
      t_prod = $signed(in_product);
      if (!m_active) begin
        m_acc = t_prod; m_cnt = 1; m_ovf = 0;
      end else begin
        t_sum = m_acc + t_prod;
        m_cnt++;
        if (t_sum > MAXV) begin
          m_ovf = 1;
`ifdef BOOTH_ACC_SAT_EN
          t_sum = MAXV;
`else
          t_sum = t_sum - MODV;
`endif
        end else if (t_sum < MINV) begin
          m_ovf = 1;
`ifdef BOOTH_ACC_SAT_EN
          t_sum = MINV;
`else
          t_sum = t_sum + MODV;
`endif
        end
        m_acc = t_sum;
      end
      m_active = 1;
      m_fresh  = 0;
      if (in_last || m_cnt == MAXB) m_hold = 1;
    end
  end

  // Presents one beat until it is accepted; returns the cycle stamp just after the accepting edge.
  task automatic beat(input logic [31:0] p, input logic last, output int acc_cyc);
    int g;
    g = 0;
    in_valid = 1'b1; in_product = p; in_last = last;
    while (!in_ready && g < 1000) begin
      @(posedge clk); #1;
      g++;
    end
    chk("beat_accept_ready", in_ready, 1);
    @(posedge clk); #1;
    acc_cyc = cyc;
    in_valid = 1'b0; in_product = $urandom; in_last = 1'($urandom);
  endtask

  task automatic release_hold();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  function automatic logic [31:0] rand_prod(input bit big);
    logic signed [15:0] a;
    logic signed [15:0] b;
    logic signed [31:0] r;
    if (big) begin
      r = ($urandom_range(0, 4) != 0) ? 32'sh4000_0000 : -32'sd1073709056;
    end else begin
      a = 16'($urandom);
      b = 16'($urandom);
      r = a * b;
    end
    return r;
  endfunction

  int c0, c1, c2;
  logic [63:0] acc_bits;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_count", out_count, 0);
    chk("reset_acc", $signed(out_acc), 0);

    // Single-beat frame, result one cycle after acceptance.
    beat(32'd56088, 1'b1, c0);
    chk("single_valid", out_valid, 1);
    chk("single_acc", $signed(out_acc), 56088);
    chk("single_count", out_count, 1);
    chk("single_ovf", out_overflow, 0);
    release_hold();

    // Three beats, consumer stalls for five cycles.
    beat(-32'sd21, 1'b0, c0);
    beat(32'sd100, 1'b0, c0);
    beat(-32'sd60000, 1'b1, c0);
    for (int i = 0; i < 5; i++) begin
      chk("stall_acc", $signed(out_acc), -59921);
      chk("stall_count", out_count, 3);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_valid", out_valid, 1);
      @(posedge clk); #1;
    end
    release_hold();

    // 32 x 2^30 reaches exactly 2^35, one past the positive limit.
    for (int i = 0; i < 32; i++) beat(32'h4000_0000, (i == 31), c0);
    acc_bits = {28'd0, out_acc};
    chk("ovf_flag", out_overflow, 1);
`ifdef BOOTH_ACC_SAT_EN
    chk("ovf_acc_sat", acc_bits, 64'h7_FFFF_FFFF);
`else
    chk("ovf_acc_wrap", acc_bits, 64'h8_0000_0000);
`endif
    chk("ovf_count", out_count, 32);
    release_hold();

    // Forced frame end after 255 beats; the next beat waits out the hold.
    for (int i = 0; i < 255; i++) beat(32'd1, 1'b0, c0);
    chk("forced_valid", out_valid, 1);
    chk("forced_count", out_count, 255);
    chk("forced_acc", $signed(out_acc), 255);
    in_valid = 1'b1; in_product = 32'd9; in_last = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("forced_wait_count", out_count, 255);
      chk("forced_wait_ready", in_ready, 0);
    end
    release_hold();
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("after_forced_acc", $signed(out_acc), 9);
    chk("after_forced_count", out_count, 1);
    chk("after_forced_ovf", out_overflow, 0);
    release_hold();

    // Reset aborts a partial frame.
    beat(32'd1, 1'b0, c0);
    beat(32'd2, 1'b0, c0);
    beat(32'd3, 1'b0, c0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_valid", out_valid, 0);
    chk("abort_count", out_count, 0);
    beat(32'd7, 1'b1, c0);
    chk("abort_next_acc", $signed(out_acc), 7);
    chk("abort_next_count", out_count, 1);
    release_hold();

    // Back-to-back frames with the consumer always ready.
    out_ready = 1'b1;
    beat(32'd5, 1'b0, c0);
    beat(32'd6, 1'b1, c1);
    chk("b2b_acc_a", $signed(out_acc), 11);
    beat(32'd10, 1'b1, c2);
    chk("b2b_gap", c2 - c1, 2);
    chk("b2b_acc_b", $signed(out_acc), 10);
    @(posedge clk); #1;

    // Random traffic, mixed frame lengths and occasional reset.
    for (int i = 0; i < 1500; i++) begin
      rst        = ($urandom_range(0, 299) == 0);
      in_valid   = ($urandom_range(0, 3) != 0);
      in_product = rand_prod(1'b0);
      in_last    = ($urandom_range(0, 5) == 0);
      out_ready  = ($urandom_range(0, 1) == 0);
      @(posedge clk); #1;
    end
    // Long frames of large products to drive the accumulator past its limits.
    for (int i = 0; i < 2500; i++) begin
      rst        = 1'b0;
      in_valid   = ($urandom_range(0, 7) != 0);
      in_product = rand_prod(1'b1);
      in_last    = ($urandom_range(0, 99) == 0);
      out_ready  = ($urandom_range(0, 2) == 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
